// File: rtl/mmu_bus_responder.sv
// mmu_bus_responder
// Responder end of the CPU memory bus: decodes HRAM, the interrupt flag and
// enable registers and the OAM DMA register, and passes every other address
// to the external memory port. It also runs the 160-byte OAM DMA copy to
// FE00, blocking the CPU's view of external memory while the copy runs.

module mmu_bus_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_select,
  input  logic        write_enable,
  input  logic [7:0]  write_value,
  output logic [7:0]  read_out,
  input  logic [4:0]  irq_req,
  output logic [7:0]  mmio_reg_IF,
  output logic [7:0]  mmio_reg_IE,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  input  logic [7:0]  ext_rdata,
  output logic        dma_active
);

  localparam logic [15:0] ADDR_IF        = 16'hFF0F;
  localparam logic [15:0] ADDR_DMA       = 16'hFF46;
  localparam logic [15:0] ADDR_IE        = 16'hFFFF;
  localparam logic [15:0] ADDR_HRAM_LO   = 16'hFF80;
  localparam logic [15:0] ADDR_HRAM_HI   = 16'hFFFE;
  localparam logic [15:0] ADDR_OAM       = 16'hFE00;
  localparam logic [7:0]  DMA_LAST_IDX   = 8'd159;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DMA_RD = 2'd1,
    ST_DMA_WR = 2'd2
  } dma_state_e;

  // Region decode
  logic sel_hram_s;
  logic sel_if_s;
  logic sel_dma_s;
  logic sel_ie_s;
  logic sel_ext_s;
  logic [6:0] hram_idx_s;

  // Register state
  logic [7:0]  read_out_q, read_out_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dma_buf_q, dma_buf_d;
  dma_state_e  state_q, state_d;
  logic [7:0]  hram_q [0:126];

  // Combinational helpers
  logic        cpu_wr_dma_s;
  logic        hram_we_s;
  logic [15:0] src_s;
  dma_state_e  fsm_state_s;
  logic [7:0]  fsm_idx_s;
  logic [15:0] ext_addr_s;
  logic [7:0]  ext_wdata_s;
  logic        ext_we_s;
  logic        dma_active_s;

  // HRAM occupies FF80..FFFE, so the low seven address bits index it directly.
  assign hram_idx_s   = addr_select[6:0];
  assign cpu_wr_dma_s = write_enable & sel_dma_s;
  assign hram_we_s    = write_enable & sel_hram_s;
  assign src_s        = {dma_reg_q, 8'h00};

  // Address decode: exactly one region select is high for any address
  always_comb begin
    sel_hram_s = 1'b0;
    sel_if_s   = 1'b0;
    sel_dma_s  = 1'b0;
    sel_ie_s   = 1'b0;
    sel_ext_s  = 1'b0;
    if ((addr_select >= ADDR_HRAM_LO) && (addr_select <= ADDR_HRAM_HI)) begin
      sel_hram_s = 1'b1;
    end else if (addr_select == ADDR_IF) begin
      sel_if_s = 1'b1;
    end else if (addr_select == ADDR_DMA) begin
      sel_dma_s = 1'b1;
    end else if (addr_select == ADDR_IE) begin
      sel_ie_s = 1'b1;
    end else begin
      sel_ext_s = 1'b1;
    end
  end

  // DMA sequencer and external port mux; a CPU write to FF46 overrides the
  // sequencer so a running copy restarts from index 0 with the new source
  always_comb begin
    fsm_state_s  = state_q;
    fsm_idx_s    = idx_q;
    dma_buf_d    = dma_buf_q;
    ext_addr_s   = addr_select;
    ext_wdata_s  = write_value;
    ext_we_s     = write_enable & sel_ext_s;
    dma_active_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fsm_state_s = ST_IDLE;
      end
      ST_DMA_RD: begin
        dma_active_s = 1'b1;
        ext_addr_s   = src_s + {8'h00, idx_q};
        ext_wdata_s  = dma_buf_q;
        ext_we_s     = 1'b0;
        dma_buf_d    = ext_rdata;
        fsm_state_s  = ST_DMA_WR;
      end
      ST_DMA_WR: begin
        dma_active_s = 1'b1;
        ext_addr_s   = ADDR_OAM + {8'h00, idx_q};
        ext_wdata_s  = dma_buf_q;
        ext_we_s     = 1'b1;
        fsm_idx_s    = idx_q + 8'd1;
        fsm_state_s  = (idx_q < DMA_LAST_IDX) ? ST_DMA_RD : ST_IDLE;
      end
      default: begin
        fsm_state_s = ST_IDLE;
      end
    endcase
    state_d = cpu_wr_dma_s ? ST_DMA_RD : fsm_state_s;
    idx_d   = cpu_wr_dma_s ? 8'd0 : fsm_idx_s;
  end

  // CPU-visible register next state and read data mux
  always_comb begin
    ie_d      = (write_enable & sel_ie_s) ? write_value : ie_q;
    dma_reg_d = cpu_wr_dma_s ? write_value : dma_reg_q;
    // An interrupt request in the same cycle as a CPU write still sets its bit.
    if_d      = ((write_enable & sel_if_s) ? write_value[4:0] : if_q) | irq_req;
    if (sel_hram_s) begin
      read_out_d = hram_q[hram_idx_s];
    end else if (sel_if_s) begin
      read_out_d = {3'b111, if_q};
    end else if (sel_ie_s) begin
      read_out_d = ie_q;
    end else if (sel_dma_s) begin
      read_out_d = dma_reg_q;
    end else begin
      read_out_d = dma_active_s ? 8'hFF : ext_rdata;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_out_q <= 8'h00;
      if_q       <= 5'h00;
      ie_q       <= 8'h00;
      dma_reg_q  <= 8'h00;
      idx_q      <= 8'h00;
      dma_buf_q  <= 8'h00;
      state_q    <= ST_IDLE;
    end else begin
      read_out_q <= read_out_d;
      if_q       <= if_d;
      ie_q       <= ie_d;
      dma_reg_q  <= dma_reg_d;
      idx_q      <= idx_d;
      dma_buf_q  <= dma_buf_d;
      state_q    <= state_d;
    end
  end

  // HRAM storage keeps its contents through reset
  always_ff @(posedge clk) begin
    if (hram_we_s) begin
      hram_q[hram_idx_s] <= write_value;
    end
  end

  assign read_out    = read_out_q;
  assign mmio_reg_IF = {3'b000, if_q};
  assign mmio_reg_IE = ie_q;
  assign ext_addr    = ext_addr_s;
  assign ext_wdata   = ext_wdata_s;
  assign ext_we      = ext_we_s;
  assign dma_active  = dma_active_s;

endmodule

// File: tb/tb_mmu_bus_responder.sv
// Self-checking bench for mmu_bus_responder: a table of single-cycle CPU
// accesses followed by directed DMA copy, blocking, restart and reset runs.
// External memory is modelled as a 64 KB array initialised to addr[7:0]^addr[15:8].

module tb_mmu_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr_select = 16'h0000;
  logic        write_enable = 1'b0;
  logic [7:0]  write_value = 8'h00;
  logic [7:0]  read_out;
  logic [4:0]  irq_req = 5'h00;
  logic [7:0]  mmio_reg_IF;
  logic [7:0]  mmio_reg_IE;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we;
  logic [7:0]  ext_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic [15:0] we_log [$];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [4:0]  irq;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_if;
    logic [7:0]  exp_ie;
    logic        exp_we;
  } vec_t;

  vec_t vecs [17];

  mmu_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .addr_select  (addr_select),
    .write_enable (write_enable),
    .write_value  (write_value),
    .read_out     (read_out),
    .irq_req      (irq_req),
    .mmio_reg_IF  (mmio_reg_IF),
    .mmio_reg_IE  (mmio_reg_IE),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_we       (ext_we),
    .ext_rdata    (ext_rdata),
    .dma_active   (dma_active)
  );

  always #5 clk = ~clk;

  assign ext_rdata = mem[ext_addr];

  // External memory model and write log
  always @(posedge clk) begin
    if (ext_we === 1'b1) begin
      mem[ext_addr] <= ext_wdata;
      we_log.push_back(ext_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU access: drive on the falling edge, return 1 ns after the rising edge
  task automatic cpu(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    write_enable = w;
    addr_select  = a;
    write_value  = d;
    irq_req      = 5'h00;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  // Wait for the DMA to finish, counting falling edges seen with dma_active high
  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!dma_active) break;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int bad;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'(a) ^ 8'(a >> 8);
    end

    //               we    addr       wd     irq    chk   rd     IF     IE     ext_we
    vecs[0]  = '{1'b1, 16'hFF80, 8'h5A, 5'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 16'hFF80, 8'h00, 5'h00, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 16'hFFFE, 8'hA7, 5'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 16'hFFFE, 8'h00, 5'h00, 1'b1, 8'hA7, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 16'hFF0F, 8'h00, 5'h04, 1'b1, 8'hE0, 8'h04, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 16'hFF0F, 8'h00, 5'h00, 1'b1, 8'hE4, 8'h04, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 16'hFFFF, 8'h1F, 5'h00, 1'b1, 8'h00, 8'h04, 8'h1F, 1'b0};
    vecs[7]  = '{1'b0, 16'hFFFF, 8'h00, 5'h00, 1'b1, 8'h1F, 8'h04, 8'h1F, 1'b0};
    vecs[8]  = '{1'b1, 16'hFF0F, 8'h1F, 5'h00, 1'b1, 8'hE4, 8'h1F, 8'h1F, 1'b0};
    vecs[9]  = '{1'b1, 16'hFF0F, 8'h00, 5'h01, 1'b1, 8'hFF, 8'h01, 8'h1F, 1'b0};
    vecs[10] = '{1'b0, 16'hFF0F, 8'h00, 5'h02, 1'b1, 8'hE1, 8'h03, 8'h1F, 1'b0};
    vecs[11] = '{1'b0, 16'hC123, 8'h00, 5'h00, 1'b1, 8'hE2, 8'h03, 8'h1F, 1'b0};
    vecs[12] = '{1'b1, 16'hC123, 8'h77, 5'h00, 1'b1, 8'hE2, 8'h03, 8'h1F, 1'b1};
    vecs[13] = '{1'b0, 16'hC123, 8'h00, 5'h00, 1'b1, 8'h77, 8'h03, 8'h1F, 1'b0};
    vecs[14] = '{1'b1, 16'hFFFF, 8'hA5, 5'h00, 1'b1, 8'h1F, 8'h03, 8'hA5, 1'b0};
    vecs[15] = '{1'b0, 16'hFFFF, 8'h00, 5'h00, 1'b1, 8'hA5, 8'h03, 8'hA5, 1'b0};
    vecs[16] = '{1'b0, 16'hFF0F, 8'h00, 5'h00, 1'b1, 8'hE3, 8'h03, 8'hA5, 1'b0};

    // Reset
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_read_out", read_out, 8'h00);
    check("rst_IF", mmio_reg_IF, 8'h00);
    check("rst_IE", mmio_reg_IE, 8'h00);
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_ext_we", ext_we, 1'b0);

    // Table of single-cycle accesses
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      write_enable = vecs[i].we;
      addr_select  = vecs[i].addr;
      write_value  = vecs[i].wd;
      irq_req      = vecs[i].irq;
      #1;
      check($sformatf("v%0d_ext_we", i), ext_we, vecs[i].exp_we);
      @(posedge clk);
      #1;
      if (vecs[i].chk_rd) check($sformatf("v%0d_read_out", i), read_out, vecs[i].exp_rd);
      check($sformatf("v%0d_IF", i), mmio_reg_IF, vecs[i].exp_if);
      check($sformatf("v%0d_IE", i), mmio_reg_IE, vecs[i].exp_ie);
    end
    @(negedge clk);
    write_enable = 1'b0;
    irq_req      = 5'h00;

    // DMA copy C000..C09F -> FE00..FE9F
    we_log.delete();
    cpu(1'b1, 16'hFF46, 8'hC0);
    check("dma_start_active", dma_active, 1'b1);
    addr_select = 16'hFF80;
    wait_idle(cyc);
    check("dma_done", dma_active, 1'b0);
    check("dma_active_cycles", cyc, 320);
    check("dma_pulses", we_log.size(), 160);
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      if (mem[16'hFE00 + k] !== (8'(k) ^ 8'hC0)) bad++;
      if (k < we_log.size()) begin
        if (we_log[k] !== 16'(16'hFE00 + k)) bad++;
      end
    end
    check("dma_copy_bad", bad, 0);

    // CPU view while a DMA runs
    cpu(1'b1, 16'hFF46, 8'hC0);
    cpu(1'b0, 16'hC000, 8'h00);
    check("blk_read_ext", read_out, 8'hFF);
    cpu(1'b1, 16'hC000, 8'h55);
    cpu(1'b1, 16'hFF90, 8'h3C);
    cpu(1'b0, 16'hFF90, 8'h00);
    check("blk_hram_rd", read_out, 8'h3C);
    cpu(1'b0, 16'hFF46, 8'h00);
    check("blk_dma_reg", read_out, 8'hC0);
    check("blk_still_active", dma_active, 1'b1);
    wait_idle(cyc);
    check("blk_done", dma_active, 1'b0);
    cpu(1'b0, 16'hC000, 8'h00);
    check("blk_write_dropped", read_out, 8'hC0);

    // Restart at i=40
    we_log.delete();
    cpu(1'b1, 16'hFF46, 8'hC1);
    for (int c = 0; c < 1000; c++) begin
      if (we_log.size() >= 40) break;
      @(posedge clk);
      #1;
    end
    cpu(1'b1, 16'hFF46, 8'hC2);
    wait_idle(cyc);
    check("rs_done", dma_active, 1'b0);
    check("rs_pulses", we_log.size(), 200);
    if (we_log.size() >= 41) begin
      check("rs_last_before", we_log[39], 16'hFE27);
      check("rs_first_after", we_log[40], 16'hFE00);
    end else begin
      check("rs_log_short", we_log.size(), 41);
    end
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      if (mem[16'hFE00 + k] !== (8'(k) ^ 8'hC2)) bad++;
    end
    check("rs_copy_bad", bad, 0);

    // Reset asserted mid-DMA while a write pulse is being driven
    cpu(1'b1, 16'hFF46, 8'hC3);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ext_we) break;
    end
    check("mr_pre_we", ext_we, 1'b1);
    rst = 1'b0;
    #1;
    check("mr_dma_active", dma_active, 1'b0);
    check("mr_ext_we", ext_we, 1'b0);
    check("mr_IF", mmio_reg_IF, 8'h00);
    check("mr_IE", mmio_reg_IE, 8'h00);
    check("mr_read_out", read_out, 8'h00);
    @(posedge clk);
    #1;
    check("mr_ext_we_held", ext_we, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cpu(1'b0, 16'hFF90, 8'h00);
    check("mr_hram_kept", read_out, 8'h3C);
    cpu(1'b0, 16'hFF46, 8'h00);
    check("mr_dma_reg", read_out, 8'h00);
    cpu(1'b0, 16'hFF0F, 8'h00);
    check("mr_if_read", read_out, 8'hE0);
    check("mr_idle", dma_active, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
